// File: rtl/fir_seq_pkg.sv
// fir_seq_pkg: shared types and defaults
// for the FIR job sequencer.
package fir_seq_pkg;

  localparam int DW_DEF        = 32;
  localparam int NSAMP_DEF     = 32;
  localparam int AW_DEF        = 5;
  localparam int FIR_LAT_DEF   = 8;
  localparam int FLUSH_CYC_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_FEED  = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_e;

endpackage

// File: rtl/fir_valid_delay.sv
// fir_valid_delay: LAT-stage valid shift
// register with synchronous clear.
module fir_valid_delay #(
  parameter int LAT = 8
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic [LAT-1:0] sr_q;

  // Shift the valid bit one stage per clock.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sr_q <= '0;
    end else if (clr_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= (sr_q << 1) | LAT'(d_i);
    end
  end

  assign q_o = sr_q[LAT-1];

endmodule

// File: rtl/fir_job_sequencer.sv
// fir_job_sequencer: flushes the FIR, streams
// X samples through it and stores results in Y.
module fir_job_sequencer
  import fir_seq_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int NSAMP     = NSAMP_DEF,
  parameter int AW        = AW_DEF,
  parameter int FIR_LAT   = FIR_LAT_DEF,
  parameter int FLUSH_CYC = FLUSH_CYC_DEF
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          start_i,
  input  logic [AW:0]   len_i,
  input  logic          abort_i,
  output logic [AW-1:0] x_rd_addr_o,
  input  logic [DW-1:0] x_rd_data_i,
  output logic [DW-1:0] fir_in_o,
  input  logic [DW-1:0] fir_out_i,
  output logic          y_wr_en_o,
  output logic [AW-1:0] y_wr_addr_o,
  output logic [DW-1:0] y_wr_data_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int FW =
    (FLUSH_CYC < 2) ? 1 : $clog2(FLUSH_CYC + 1);
  localparam logic [AW:0] NS_L = (AW+1)'(NSAMP);
  localparam logic [FW-1:0] FL_L = FW'(FLUSH_CYC);

  seq_state_e    state_q;
  seq_state_e    state_d;

  logic [AW:0]   len_q;
  logic [AW:0]   len_clamp;
  logic [AW:0]   rd_cnt;
  logic [AW:0]   wr_cnt;
  logic [AW:0]   wr_cnt_inc;
  logic [FW-1:0] flush_cnt;
  logic          done_q;

  logic          start_ok;
  logic          abort_act;
  logic          flush_last;
  logic          feed_last;
  logic          drain_done;
  logic          feed_v;
  logic          wr_v;

  assign len_clamp =
    (len_i > NS_L) ? NS_L : len_i;

  assign start_ok =
    (state_q == ST_IDLE) && start_i && !abort_i;

  assign abort_act =
    abort_i && (state_q != ST_IDLE);

  assign flush_last = (flush_cnt == FW'(1));

  assign feed_last = (rd_cnt == len_q - 1'b1);

  assign wr_cnt_inc =
    wr_cnt + {{AW{1'b0}}, wr_v};

  // DRAIN ends in the cycle carrying the final write.
  assign drain_done = (wr_cnt_inc == len_q);

  assign feed_v = (state_q == ST_FEED);

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; abort overrides everything.
  always_comb begin
    state_d = state_q;
    if (abort_act) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_ok && (len_clamp != '0)) begin
            state_d = (FLUSH_CYC == 0) ?
                      ST_FEED : ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (flush_last) state_d = ST_FEED;
        end
        ST_FEED: begin
          if (feed_last) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drain_done) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Job counters, captured length and sticky done.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      len_q     <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      flush_cnt <= '0;
      done_q    <= 1'b0;
    end else if (abort_act) begin
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      flush_cnt <= '0;
    end else if (start_ok) begin
      len_q     <= len_clamp;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      flush_cnt <= FL_L;
      done_q    <= (len_clamp == '0);
    end else begin
      if (state_q == ST_FLUSH) begin
        flush_cnt <= flush_cnt - 1'b1;
      end
      if (state_q == ST_FEED) begin
        rd_cnt <= feed_last ? '0 : rd_cnt + 1'b1;
      end
      wr_cnt <= wr_cnt_inc;
      if ((state_q == ST_DRAIN) && drain_done) begin
        done_q <= 1'b1;
      end
    end
  end

  fir_valid_delay #(
    .LAT      (FIR_LAT)
  ) u_vdly (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .clr_i    (abort_act),
    .d_i      (feed_v),
    .q_o      (wr_v)
  );

  // Output decode; only the FIR feed is combinational.
  always_comb begin
    busy_o   = 1'b0;
    fir_in_o = '0;
    unique case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
      end
      ST_FLUSH,
      ST_DRAIN: begin
        busy_o = 1'b1;
      end
      ST_FEED: begin
        busy_o   = 1'b1;
        fir_in_o = x_rd_data_i;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  assign x_rd_addr_o = rd_cnt[AW-1:0];
  assign done_o      = done_q;

  // Write strobe and address come from registers;
  // data is the FIR output register, gated by the strobe.
  assign y_wr_en_o   = wr_v;
  assign y_wr_addr_o = wr_v ? wr_cnt[AW-1:0] : '0;
  assign y_wr_data_o = wr_v ? fir_out_i : '0;

endmodule

// File: tb/tb_fir_job_sequencer.sv
// tb_fir_job_sequencer: scoreboard bench with
// an ideal 8-cycle FIR and a combinational X buffer.
module tb_fir_job_sequencer;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          start_i;
  logic [AW:0]   len_i;
  logic          abort_i;
  logic [AW-1:0] x_rd_addr_o;
  logic [DW-1:0] x_rd_data_i;
  logic [DW-1:0] fir_in_o;
  logic [DW-1:0] fir_out_i;
  logic          y_wr_en_o;
  logic [AW-1:0] y_wr_addr_o;
  logic [DW-1:0] y_wr_data_o;
  logic          busy_o;
  logic          done_o;

  fir_job_sequencer dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .start_i     (start_i),
    .len_i       (len_i),
    .abort_i     (abort_i),
    .x_rd_addr_o (x_rd_addr_o),
    .x_rd_data_i (x_rd_data_i),
    .fir_in_o    (fir_in_o),
    .fir_out_i   (fir_out_i),
    .y_wr_en_o   (y_wr_en_o),
    .y_wr_addr_o (y_wr_addr_o),
    .y_wr_data_o (y_wr_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cyc = 0;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  logic [DW-1:0] xmem [32];
  assign x_rd_data_i = xmem[x_rd_addr_o];

  logic [DW-1:0] fpipe [8];
  always @(posedge wb_clk_i) begin
    fpipe[0] <= fir_in_o;
    for (int i = 1; i < 8; i++) fpipe[i] <= fpipe[i-1];
  end
  assign fir_out_i = fpipe[7];

  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          cyc;
    logic        busy;
    logic        done;
    logic [31:0] fin;
    int          xa;
  } st_t;

  wr_t sbq[$];
  st_t stq[$];

  int  checks = 0;
  int  errors = 0;
  bit  fin_req = 0;
  bit  fin_done = 0;

  // Monitor: all comparisons happen here.
  initial begin
    wr_t e;
    st_t s;
    forever begin
      @(negedge wb_clk_i);
      while (stq.size() > 0 && stq[0].cyc <= cyc) begin
        s = stq.pop_front();
        checks++;
        if (s.cyc != cyc || busy_o !== s.busy ||
            done_o !== s.done || fir_in_o !== s.fin ||
            int'(x_rd_addr_o) != s.xa) begin
          errors++;
          $display("FAIL status cyc=%0d got busy=%0b done=%0b fin=%0d xa=%0d exp cyc=%0d busy=%0b done=%0b fin=%0d xa=%0d",
                   cyc, busy_o, done_o, fir_in_o, x_rd_addr_o,
                   s.cyc, s.busy, s.done, s.fin, s.xa);
        end
      end
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        e = sbq.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_wr exp cyc=%0d addr=%0d data=%0d got none",
                 e.cyc, e.addr, e.data);
      end
      if (y_wr_en_o) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_wr cyc=%0d got addr=%0d data=%0d exp no write",
                   cyc, y_wr_addr_o, y_wr_data_o);
        end else begin
          e = sbq.pop_front();
          if (e.cyc != cyc || int'(y_wr_addr_o) != e.addr ||
              y_wr_data_o !== e.data) begin
            errors++;
            $display("FAIL y_wr got cyc=%0d addr=%0d data=%0d exp cyc=%0d addr=%0d data=%0d",
                     cyc, y_wr_addr_o, y_wr_data_o,
                     e.cyc, e.addr, e.data);
          end
        end
      end
      if (fin_req && !fin_done) begin
        checks += 2;
        if (sbq.size() != 0) begin
          errors++;
          $display("FAIL wr_left got %0d exp 0", sbq.size());
        end
        if (stq.size() != 0) begin
          errors++;
          $display("FAIL st_left got %0d exp 0", stq.size());
        end
        fin_done = 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic push_st(input int c, input logic b,
                         input logic d, input int f,
                         input int xa);
    st_t s;
    s.cyc  = c;
    s.busy = b;
    s.done = d;
    s.fin  = f;
    s.xa   = xa;
    stq.push_back(s);
  endtask

  task automatic start_job(input int len, input int xbase,
                           input int nwr, output int s);
    wr_t e;
    for (int k = 0; k < 32; k++) xmem[k] = xbase + k;
    start_i = 1'b1;
    len_i   = (AW+1)'(len);
    tick(1);
    s       = cyc;
    start_i = 1'b0;
    for (int k = 0; k < nwr; k++) begin
      e.cyc  = s + 16 + k;
      e.addr = k;
      e.data = xbase + k;
      sbq.push_back(e);
    end
  endtask

  initial begin
    int s;
    int s2;
    wb_rst_i = 1'b1;
    start_i  = 1'b0;
    abort_i  = 1'b0;
    len_i    = '0;
    for (int k = 0; k < 32; k++) xmem[k] = '0;
    tick(2);
    push_st(cyc, 0, 0, 0, 0);
    tick(1);
    wb_rst_i = 1'b0;
    tick(2);

    start_job(32, 1, 32, s);
    push_st(s,      1, 0, 0, 0);
    push_st(s + 3,  1, 0, 0, 0);
    push_st(s + 8,  1, 0, 1, 0);
    push_st(s + 13, 1, 0, 6, 5);
    push_st(s + 40, 1, 0, 0, 0);
    push_st(s + 47, 1, 0, 0, 0);
    push_st(s + 48, 0, 1, 0, 0);
    tick_to(s + 10);
    start_i = 1'b1;
    len_i   = 6'd3;
    tick(1);
    start_i = 1'b0;
    tick_to(s + 48);
    start_job(32, 101, 32, s2);
    push_st(s2 + 47, 1, 0, 0, 0);
    push_st(s2 + 48, 0, 1, 0, 0);
    tick_to(s2 + 50);

    start_job(32, 1, 4, s);
    push_st(s,      1, 0, 0, 0);
    push_st(s + 10, 1, 0, 3, 2);
    push_st(s + 20, 0, 0, 0, 0);
    push_st(s + 25, 0, 0, 0, 0);
    tick_to(s + 19);
    abort_i = 1'b1;
    tick(1);
    abort_i = 1'b0;
    tick_to(s + 30);

    start_job(0, 1, 0, s);
    push_st(s,     0, 1, 0, 0);
    push_st(s + 3, 0, 1, 0, 0);
    tick(4);

    start_i = 1'b1;
    abort_i = 1'b1;
    len_i   = 6'd5;
    tick(1);
    s       = cyc;
    start_i = 1'b0;
    abort_i = 1'b0;
    push_st(s,     0, 1, 0, 0);
    push_st(s + 2, 0, 1, 0, 0);
    tick(3);

    start_job(40, 201, 32, s);
    push_st(s + 39, 1, 0, 232, 31);
    push_st(s + 47, 1, 0, 0, 0);
    push_st(s + 48, 0, 1, 0, 0);
    tick_to(s + 50);

    start_job(32, 1, 13, s);
    tick_to(s + 29);
    wb_rst_i = 1'b1;
    push_st(s + 29, 0, 0, 0, 0);
    tick(2);
    wb_rst_i = 1'b0;
    tick(2);

    start_job(32, 51, 32, s);
    push_st(s + 48, 0, 1, 0, 0);
    tick_to(s + 52);

    fin_req = 1;
    @(negedge wb_clk_i);
    #1;
    if (!fin_done) $fatal(1, "FAIL monitor_end not reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
